// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART byte stream between N_REQ requesters,
// with optional ASCII source tag, CR LF trailer and mid-message stall abort.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter bit TAG_EN  = 1'b1,
    parameter bit EOL_EN  = 1'b1,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_pulse
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_BODY,
        S_CR,
        S_LF,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pulse_q, pulse_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;
    logic              loadable;
    logic              cur_valid;
    logic              cur_last;
    logic [7:0]        cur_data;
    logic              cur_ready;
    logic              cur_fire;
    state_t            end_state;

    // First valid requester after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign loadable  = !out_valid_q || out_ready;
    assign cur_valid = req_valid[idx_q];
    assign cur_last  = req_last[idx_q];
    assign cur_data  = req_data[{idx_q, 3'b000} +: 8];
    // In TAG the register always holds the tag, so the first body byte can ride in as it drains.
    assign cur_ready = ((state_q == S_TAG) || (state_q == S_BODY)) && loadable;
    assign cur_fire  = cur_valid && cur_ready;
    assign end_state = EOL_EN ? S_CR : S_DRAIN;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        cnt_d       = '0;
        pulse_d     = 1'b0;

        if (cur_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = cur_data;
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = N_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    rr_d    = win_idx;
                    if (TAG_EN) begin
                        state_d     = S_TAG;
                        out_valid_d = 1'b1;
                        out_data_d  = 8'h30 + 8'(win_idx);
                    end else begin
                        state_d = S_BODY;
                    end
                end
            end
            S_TAG: begin
                if (cur_fire) begin
                    state_d = cur_last ? end_state : S_BODY;
                end else if (out_ready) begin
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                cnt_d = cnt_q;
                if (cur_fire) begin
                    cnt_d = '0;
                    if (cur_last) begin
                        state_d = end_state;
                    end
                end else if (!cur_valid && (TIMEOUT > 0)) begin
                    // Only requester silence counts; output backpressure holds the count.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        state_d = end_state;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CR: begin
                if (loadable) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h0D;
                    state_d     = S_LF;
                end
            end
            S_LF: begin
                if (loadable) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h0A;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (loadable) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            rr_q        <= IW'(N_REQ - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    assign req_ready     = grant_q & {N_REQ{cur_ready}};
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level round-robin reference model driven by queued
// requester messages, with random backpressure and in-message gaps.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req_valid, req_last, req_ready, grant;
    logic [8*N-1:0]   req_data;
    logic             out_valid, out_ready, busy, timeout_pulse;
    logic [7:0]       out_data;

    logic [N-1:0]     b_req_valid, b_req_last, b_req_ready, b_grant;
    logic [8*N-1:0]   b_req_data;
    logic             b_out_valid, b_out_ready, b_busy, b_timeout_pulse;
    logic [7:0]       b_out_data;

    uart_tx_arbiter #(.N_REQ(N), .TAG_EN(1'b1), .EOL_EN(1'b1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    uart_tx_arbiter #(.N_REQ(N), .TAG_EN(1'b0), .EOL_EN(1'b0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_data(b_req_data), .req_last(b_req_last), .req_ready(b_req_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .grant(b_grant), .busy(b_busy), .timeout_pulse(b_timeout_pulse)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] src_mem [N][64];
    int         src_len [N];
    int         src_pos [N];
    int         idle_run [N];
    logic [7:0] exp_q[$];
    int         out_cyc_q[$];
    bit         ready_pat[$];
    int         cyc_n = 0;
    int         pulse_cnt = 0;
    int         pulse_cyc = 0;
    bit         rnd_ready = 1'b0;
    bit         gap_en = 1'b0;
    bit         grant_chk = 1'b0;
    logic [N-1:0] exp_grant = '0;
    bit         stall_prev = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_pos[i]  = 0;
            idle_run[i] = 0;
        end
        exp_q.delete();
        out_cyc_q.delete();
        ready_pat.delete();
        stall_prev = 1'b0;
        pulse_cnt  = 0;
        grant_chk  = 1'b0;
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input bit l);
        src_mem[i][src_len[i]] = {l, d};
        src_len[i]++;
    endtask

    // Whole messages in round-robin order among requesters that still have messages queued.
    task automatic model_rr(input int rr_start);
        int pos [N];
        int p;
        bit found;
        bit fin;
        p = rr_start;
        for (int i = 0; i < N; i++) pos[i] = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && pos[(p + k) % N] < src_len[(p + k) % N]) begin
                    found = 1'b1;
                    p = (p + k) % N;
                end
            end
            if (found) begin
                exp_q.push_back(8'h30 + 8'(p));
                fin = 1'b0;
                while (!fin && pos[p] < src_len[p]) begin
                    exp_q.push_back(src_mem[p][pos[p]][7:0]);
                    fin = src_mem[p][pos[p]][8];
                    pos[p]++;
                end
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    function automatic bit all_consumed();
        bit r = 1'b1;
        for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) r = 1'b0;
        return r;
    endfunction

    task automatic cyc();
        logic mid;
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            if (src_pos[i] < src_len[i]) begin
                mid = (src_pos[i] > 0) && !src_mem[i][src_pos[i] - 1][8];
                if (gap_en && mid && idle_run[i] < 5 && $urandom_range(0, 3) == 0) begin
                    idle_run[i]++;
                end else begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
                    req_last[i] = src_mem[i][src_pos[i]][8];
                end
            end
        end
        if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
        else out_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
        #1;
        if (timeout_pulse) begin
            pulse_cnt++;
            pulse_cyc = cyc_n;
        end
        chk("req_ready_onehot_granted", {31'd0, $onehot0(req_ready) && ((req_ready & ~grant) == '0)}, 32'd1);
        if (stall_prev) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {24'd0, out_data}, {24'd0, held});
        end
        if (out_valid && !out_ready) chk("ready_when_full", {28'd0, req_ready}, 32'd0);
        if (grant_chk && out_valid) chk("grant_hold", {28'd0, grant}, {28'd0, exp_grant});
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                src_pos[i]++;
                idle_run[i] = 0;
            end
        end
        if (out_valid && out_ready) begin
            out_cyc_q.push_back(cyc_n);
            if (exp_q.size() == 0) chk("extra_out_byte", 32'(exp_q.size()), 32'd1);
            else chk("out_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
        stall_prev = out_valid && !out_ready;
        held = out_data;
    endtask

    task automatic run_done(input string tag, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            cyc();
            n++;
            done = (exp_q.size() == 0) && !busy && all_consumed();
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset(input bit check_vals);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (check_vals) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
            chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
            chk("rst_grant", {28'd0, grant}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_pulse", {31'd0, timeout_pulse}, 32'd0);
        end
        rst = 1'b0;
        clear_sources();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int nm;
        int len;
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        b_req_valid = '0; b_req_last = '0; b_req_data = '0; b_out_ready = 1'b1;
        clear_sources();
        do_reset(1'b1);

        // Tagged "AB" from requester 1 with no backpressure: five bytes on consecutive cycles.
        push_byte(1, 8'h41, 1'b0);
        push_byte(1, 8'h42, 1'b1);
        model_rr(N - 1);
        grant_chk = 1'b1;
        exp_grant = 4'b0010;
        s = cyc_n + 1;
        run_done("ab_done", 30);
        chk("ab_count", 32'(out_cyc_q.size()), 32'd5);
        for (int k = 0; k < out_cyc_q.size(); k++) chk("ab_cycle", 32'(out_cyc_q[k]), 32'(s + 1 + k));
        chk("ab_busy_fall", 32'(cyc_n), 32'(s + 6));
        grant_chk = 1'b0;

        // All four requesters with back-to-back 1-byte messages.
        do_reset(1'b0);
        for (int i = 0; i < N; i++) begin
            push_byte(i, 8'h61 + 8'(i), 1'b1);
            push_byte(i, 8'h71 + 8'(i), 1'b1);
        end
        model_rr(N - 1);
        run_done("rr_done", 200);

        // "XYZ" from requester 2 under a stall pattern.
        do_reset(1'b0);
        push_byte(2, 8'h58, 1'b0);
        push_byte(2, 8'h59, 1'b0);
        push_byte(2, 8'h5A, 1'b1);
        model_rr(N - 1);
        ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_done("bp_done", 60);

        // Requester 0 stalls mid-message while requester 3 waits.
        do_reset(1'b0);
        push_byte(0, 8'h51, 1'b0);
        push_byte(3, 8'h5A, 1'b1);
        exp_q = '{8'h30, 8'h51, 8'h0D, 8'h0A, 8'h33, 8'h5A, 8'h0D, 8'h0A};
        s = cyc_n + 1;
        run_done("tmo_done", 80);
        chk("tmo_pulse_count", 32'(pulse_cnt), 32'd1);
        chk("tmo_pulse_cycle", 32'(pulse_cyc), 32'(s + 10));

        // Reset while requester 1 is mid-body.
        do_reset(1'b0);
        for (int b = 0; b < 6; b++) push_byte(1, 8'h40 + 8'(b), b == 5);
        model_rr(N - 1);
        repeat (4) cyc();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_grant", {28'd0, grant}, 32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        rst = 1'b0;
        clear_sources();
        push_byte(0, 8'h61, 1'b1);
        push_byte(1, 8'h62, 1'b1);
        model_rr(N - 1);
        run_done("post_rst_done", 60);

        // Randomised contents, backpressure and short in-message gaps.
        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0);
            for (int i = 0; i < N; i++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(32, 126)), b == len - 1);
                end
            end
            model_rr(N - 1);
            rnd_ready = 1'b1;
            gap_en = 1'b1;
            run_done("rand_done", 2000);
            chk("rand_no_abort", 32'(pulse_cnt), 32'd0);
            rnd_ready = 1'b0;
            gap_en = 1'b0;
        end

        // Untagged, no trailer, timeout disabled: single byte from requester 3.
        @(negedge clk);
        b_req_valid = 4'b1000;
        b_req_data  = {8'h55, 24'h000000};
        b_req_last  = 4'b1000;
        b_out_ready = 1'b1;
        #1;
        chk("b_idle_ready", {28'd0, b_req_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("b_body_ready", {28'd0, b_req_ready}, 32'h8);
        chk("b_body_grant", {28'd0, b_grant}, 32'h8);
        chk("b_body_no_tag", {31'd0, b_out_valid}, 32'd0);
        @(negedge clk);
        b_req_valid = '0;
        b_req_last  = '0;
        #1;
        chk("b_out_valid", {31'd0, b_out_valid}, 32'd1);
        chk("b_out_data", {24'd0, b_out_data}, 32'h55);
        chk("b_busy", {31'd0, b_busy}, 32'd1);
        @(negedge clk);
        #1;
        chk("b_no_eol_valid", {31'd0, b_out_valid}, 32'd0);
        chk("b_idle_busy", {31'd0, b_busy}, 32'd0);
        chk("b_idle_grant", {28'd0, b_grant}, 32'd0);
        @(negedge clk);
        #1;
        chk("b_still_quiet", {31'd0, b_out_valid}, 32'd0);
        chk("b_no_pulse", {31'd0, b_timeout_pulse}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
